spi_master: RTL and testbench
=============================

SPI_MASTER -- requirements
Module: SPI_Master

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset, port names as below.
REQ-002 clk_master  input  1  rising-edge clock for all state.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 Nk_val  input  2  key size select: 00 = AES-128 (Nk=4, Nr=10); 01 = AES-192 (Nk=6, Nr=12); 10 = AES-256 (Nk=8, Nr=14); 11 = AES-128.
REQ-005 data_in  input  128  plaintext for the encrypt pass, ciphertext for the decrypt pass; data_in[127:120] = byte 0, state loaded column-major per FIPS-197.
REQ-006 key  input  256  cipher key, right-aligned: key[32*Nk-1:0]; most significant 32-bit word = w[0]; unused upper bits ignored.
REQ-007 done_out_Enc  output  1  one-cycle pulse: encrypt result valid on data_out.
REQ-008 done_out_Dec  output  1  one-cycle pulse: decrypt result valid on data_out.
REQ-009 data_out  output  128  result register, same byte order as data_in.

Function
REQ-010 The block SHALL implement FIPS-197 AES encryption followed by the standard inverse cipher on one key, with states IDLE, KEYEXP, ENC, ENC_DONE, DEC, DEC_DONE, HALT.
REQ-011 IDLE: on the first rising edge with rst low, the block SHALL capture Nk_val, key and data_in and go to KEYEXP.
REQ-012 KEYEXP SHALL generate one schedule word per edge, words Nk..4(Nr+1)-1 (40/46/52 edges for 128/192/256), store all words in an internal schedule, then go to ENC.
REQ-013 ENC SHALL take Nr+1 edges: edge 1 AddRoundKey(rk0); edges 2..Nr full rounds (SubBytes, ShiftRows, MixColumns, AddRoundKey); edge Nr+1 final round without MixColumns, result loaded into data_out, go to ENC_DONE.
REQ-014 done_out_Enc SHALL be high exactly during the single ENC_DONE cycle; resulting rise at edge 52/60/68 after reset release for AES-128/192/256.
REQ-015 On the edge leaving ENC_DONE the block SHALL capture data_in as the decrypt state and go to DEC; data_in is not sampled at any other time after IDLE.
REQ-016 DEC SHALL take Nr+1 edges using the stored schedule in reverse: AddRoundKey(rkNr); Nr-1 inverse rounds (InvShiftRows, InvSubBytes, AddRoundKey, InvMixColumns); final inverse round without InvMixColumns; result loaded into data_out, go to DEC_DONE.
REQ-017 done_out_Dec SHALL be high exactly during the single DEC_DONE cycle, Nr+2 edges after done_out_Enc rises; then the block SHALL go to HALT.
REQ-018 HALT SHALL persist until reset; both done outputs low, data_out holds the decrypt result.
REQ-019 done_out_Enc and done_out_Dec SHALL never be high in the same cycle.
REQ-020 Changes to Nk_val or key after the IDLE capture SHALL have no effect until the next reset.
REQ-021 S-box and inverse S-box MAY be tables or GF(2^8) inverse plus affine transform; results SHALL match FIPS-197 exactly.
REQ-022 GF(2^8) arithmetic SHALL use polynomial 0x11B; Rcon sequence 01,02,04,...,36; AES-256 applies SubWord on i mod Nk = 4.

Reset
REQ-023 While rst is high, the block SHALL be in IDLE with data_out = 0, done_out_Enc = 0, done_out_Dec = 0, and round/word counters at 0, independent of the clock.
REQ-024 Reset asserted mid-operation SHALL abort immediately; after release the sequence restarts from IDLE with fresh input capture.

Verification
REQ-025 AES-192: key 000102..1617, data_in 00112233445566778899aabbccddeeff, Nk_val 01 -> done_out_Enc at edge 60, data_out dda97ca4864cdfe06eaf70a0ec0d7191; bench then drives that ciphertext -> done_out_Dec, data_out 00112233445566778899aabbccddeeff.
REQ-026 AES-128: key 000102..0e0f, same plaintext, Nk_val 00 -> done_out_Enc at edge 52, data_out 69c4e0d86a7b0430d8cdb78070b4c55a; decrypt round trip returns the plaintext at edge 64.
REQ-027 AES-256: key 000102..1e1f, same plaintext, Nk_val 10 -> data_out 8ea2b7ca516745bfeafc49904b496089 at edge 68; round trip returns the plaintext.
REQ-028 Reset pulse during KEYEXP and during DEC -> outputs cleared immediately; rerun produces correct results.
REQ-029 Toggle key, Nk_val and data_in during KEYEXP/ENC -> results unchanged; done pulses exactly one cycle; after HALT no further pulses for 100 cycles.

Source files
------------

// File: rtl/spi_master.sv
// Iterative AES core: expands the key, runs one encrypt pass and one inverse-cipher pass
// on the same schedule, then halts until reset. One schedule word or one round per clock.
module spi_master (
  input  logic         clk_master,
  input  logic         rst,
  input  logic [1:0]   Nk_val,
  input  logic [127:0] data_in,
  input  logic [255:0] key,
  output logic         done_out_Enc,
  output logic         done_out_Dec,
  output logic [127:0] data_out
);
  typedef enum logic [2:0] {IDLE, KEYEXP, ENC, ENC_DONE, DEC, DEC_DONE, HALT} state_t;

  state_t       state, state_nxt;
  logic [1:0]   ksel;
  logic [3:0]   nk, nr, nk_in, rnd, rk_sel;
  logic [5:0]   wcnt, wlast;
  logic [2:0]   kmod;
  logic [7:0]   rcon;
  logic [127:0] st, rk, sr, isr, enc_nxt, dec_nxt;
  logic [255:0] key_al;
  logic [31:0]  w [0:63];
  logic [31:0]  w_prev, w_tmp, w_new;

  function automatic logic [7:0] xt(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] aa;
    p  = 8'h00;
    aa = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ aa;
      aa = xt(aa);
    end
    return p;
  endfunction

  // x^254 is the multiplicative inverse in GF(2^8) and maps 0 to 0
  function automatic logic [7:0] ginv(input logic [7:0] x);
    logic [7:0] p;
    logic [7:0] r;
    p = x;
    r = 8'h01;
    for (int i = 1; i < 8; i++) begin
      p = gmul(p, p);
      r = gmul(r, p);
    end
    return r;
  endfunction

  function automatic logic [7:0] rotl(input logic [7:0] b, input int n);
    return (b << n) | (b >> (8 - n));
  endfunction

  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] v;
    v = ginv(x);
    return v ^ rotl(v, 1) ^ rotl(v, 2) ^ rotl(v, 3) ^ rotl(v, 4) ^ 8'h63;
  endfunction

  function automatic logic [7:0] isbox(input logic [7:0] s);
    return ginv(rotl(s, 1) ^ rotl(s, 3) ^ rotl(s, 6) ^ 8'h05);
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] x);
    return {sbox(x[31:24]), sbox(x[23:16]), sbox(x[15:8]), sbox(x[7:0])};
  endfunction

  // Byte n sits at row n%4, column n/4; ShiftRows pulls row r from column c+r
  function automatic logic [127:0] sub_shift(input logic [127:0] s);
    logic [127:0] o;
    int src;
    o = '0;
    for (int n = 0; n < 16; n++) begin
      src = 4 * (((n / 4) + (n % 4)) % 4) + (n % 4);
      o[127-8*n -: 8] = sbox(s[127-8*src -: 8]);
    end
    return o;
  endfunction

  function automatic logic [127:0] inv_sub_shift(input logic [127:0] s);
    logic [127:0] o;
    int src;
    o = '0;
    for (int n = 0; n < 16; n++) begin
      src = 4 * (((n / 4) + 4 - (n % 4)) % 4) + (n % 4);
      o[127-8*n -: 8] = isbox(s[127-8*src -: 8]);
    end
    return o;
  endfunction

  function automatic logic [127:0] mix(input logic [127:0] s);
    logic [127:0] o;
    logic [7:0] a0, a1, a2, a3;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      a0 = s[127-32*c -: 8];
      a1 = s[119-32*c -: 8];
      a2 = s[111-32*c -: 8];
      a3 = s[103-32*c -: 8];
      o[127-32*c -: 8] = xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3;
      o[119-32*c -: 8] = a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3;
      o[111-32*c -: 8] = a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3;
      o[103-32*c -: 8] = xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3);
    end
    return o;
  endfunction

  function automatic logic [127:0] inv_mix(input logic [127:0] s);
    logic [127:0] o;
    logic [7:0] a0, a1, a2, a3;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      a0 = s[127-32*c -: 8];
      a1 = s[119-32*c -: 8];
      a2 = s[111-32*c -: 8];
      a3 = s[103-32*c -: 8];
      o[127-32*c -: 8] = gmul(a0, 8'h0e) ^ gmul(a1, 8'h0b) ^ gmul(a2, 8'h0d) ^ gmul(a3, 8'h09);
      o[119-32*c -: 8] = gmul(a0, 8'h09) ^ gmul(a1, 8'h0e) ^ gmul(a2, 8'h0b) ^ gmul(a3, 8'h0d);
      o[111-32*c -: 8] = gmul(a0, 8'h0d) ^ gmul(a1, 8'h09) ^ gmul(a2, 8'h0e) ^ gmul(a3, 8'h0b);
      o[103-32*c -: 8] = gmul(a0, 8'h0b) ^ gmul(a1, 8'h0d) ^ gmul(a2, 8'h09) ^ gmul(a3, 8'h0e);
    end
    return o;
  endfunction

  always_comb begin
    nk = 4'd4;
    nr = 4'd10;
    case (ksel)
      2'b01:   begin nk = 4'd6; nr = 4'd12; end
      2'b10:   begin nk = 4'd8; nr = 4'd14; end
      default: ;
    endcase
    case (Nk_val)
      2'b01:   nk_in = 4'd6;
      2'b10:   nk_in = 4'd8;
      default: nk_in = 4'd4;
    endcase
    wlast  = {nr + 4'd1, 2'b00} - 6'd1;
    key_al = key << {4'd8 - nk_in, 5'b00000};
  end

  // Key schedule step: next word from w[i-1] and w[i-Nk]
  always_comb begin
    w_prev = w[wcnt - 6'd1];
    if (kmod == 3'd0)
      w_tmp = sub_word({w_prev[23:0], w_prev[31:24]}) ^ {rcon, 24'h000000};
    else if (nk == 4'd8 && kmod == 3'd4)
      w_tmp = sub_word(w_prev);
    else
      w_tmp = w_prev;
    w_new = w[wcnt - {2'b00, nk}] ^ w_tmp;
  end

  // Round datapath: decrypt walks the schedule from rkNr down to rk0
  always_comb begin
    rk_sel = (state == DEC) ? nr - rnd : rnd;
    rk     = {w[{rk_sel, 2'b00}], w[{rk_sel, 2'b01}], w[{rk_sel, 2'b10}], w[{rk_sel, 2'b11}]};
    sr     = sub_shift(st);
    isr    = inv_sub_shift(st);
    if (rnd == 4'd0) begin
      enc_nxt = st ^ rk;
      dec_nxt = st ^ rk;
    end else if (rnd == nr) begin
      enc_nxt = sr ^ rk;
      dec_nxt = isr ^ rk;
    end else begin
      enc_nxt = mix(sr) ^ rk;
      dec_nxt = inv_mix(isr ^ rk);
    end
  end

  always_ff @(posedge clk_master or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt    = state;
    done_out_Enc = 1'b0;
    done_out_Dec = 1'b0;
    case (state)
      IDLE:     state_nxt = KEYEXP;
      KEYEXP:   if (wcnt == wlast) state_nxt = ENC;
      ENC:      if (rnd == nr) state_nxt = ENC_DONE;
      ENC_DONE: begin state_nxt = DEC; done_out_Enc = 1'b1; end
      DEC:      if (rnd == nr) state_nxt = DEC_DONE;
      DEC_DONE: begin state_nxt = HALT; done_out_Dec = 1'b1; end
      default:  state_nxt = HALT;
    endcase
  end

  always_ff @(posedge clk_master or posedge rst) begin
    if (rst) begin
      ksel     <= 2'b00;
      wcnt     <= 6'd0;
      kmod     <= 3'd0;
      rcon     <= 8'h00;
      rnd      <= 4'd0;
      data_out <= '0;
    end else begin
      case (state)
        IDLE: begin
          ksel <= Nk_val;
          wcnt <= {2'b00, nk_in};
          kmod <= 3'd0;
          rcon <= 8'h01;
          rnd  <= 4'd0;
        end
        KEYEXP: begin
          wcnt <= wcnt + 6'd1;
          kmod <= (kmod == 3'(nk - 4'd1)) ? 3'd0 : kmod + 3'd1;
          if (kmod == 3'd0) rcon <= xt(rcon);
        end
        ENC, DEC: begin
          rnd <= (rnd == nr) ? 4'd0 : rnd + 4'd1;
          if (rnd == nr) data_out <= (state == ENC) ? enc_nxt : dec_nxt;
        end
        default: ;
      endcase
    end
  end

  // Working state and schedule storage carry no reset; control decides when they are valid
  always_ff @(posedge clk_master) begin
    case (state)
      IDLE: begin
        st <= data_in;
        for (int j = 0; j < 8; j++) w[j] <= key_al[255-32*j -: 32];
      end
      KEYEXP:   w[wcnt] <= w_new;
      ENC:      st <= enc_nxt;
      ENC_DONE: st <= data_in;
      DEC:      st <= dec_nxt;
      default:  ;
    endcase
  end
endmodule

// File: tb/tb_spi_master.sv
// Scoreboard bench for spi_master: a byte-matrix AES model predicts each done pulse,
// its edge number and data_out; stimulus scrambles inputs whenever they must be ignored.
module tb_spi_master;
  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [1:0]   nk_val = 2'b00;
  logic [127:0] data_in = '0;
  logic [255:0] key = '0;
  logic         done_enc, done_dec;
  logic [127:0] data_out;
  int           n_vec = 0;
  int           n_err = 0;
  int           cyc;
  logic         prev_enc = 1'b0;
  logic         prev_dec = 1'b0;

  typedef struct { bit dec; logic [127:0] data; int edge_no; } exp_t;
  exp_t       sb[$];
  logic [7:0] sb_t [256];

  spi_master dut (
    .clk_master  (clk),
    .rst         (rst),
    .Nk_val      (nk_val),
    .data_in     (data_in),
    .key         (key),
    .done_out_Enc(done_enc),
    .done_out_Dec(done_dec),
    .data_out    (data_out)
  );

  always #5 clk = ~clk;

  always @(posedge clk or posedge rst)
    if (rst) cyc <= 0;
    else     cyc <= cyc + 1;

  function automatic logic [7:0] gm(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    logic [7:0] x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = x[7] ? ((x << 1) ^ 8'h1b) : (x << 1);
    end
    return p;
  endfunction

  function automatic logic [31:0] subw(input logic [31:0] x);
    return {sb_t[x[31:24]], sb_t[x[23:16]], sb_t[x[15:8]], sb_t[x[7:0]]};
  endfunction

  function automatic int nk_of(input logic [1:0] s);
    return (s == 2'b01) ? 6 : (s == 2'b10) ? 8 : 4;
  endfunction

  function automatic logic [127:0] rnd128();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  function automatic logic [255:0] rnd256();
    return {rnd128(), rnd128()};
  endfunction

  function automatic logic [127:0] ref_enc(input logic [255:0] k, input int nk, input logic [127:0] pt);
    logic [31:0]  w [60];
    logic [7:0]   s [4][4];
    logic [7:0]   t [4][4];
    logic [31:0]  tmp;
    logic [7:0]   rc;
    logic [127:0] o;
    int nr;
    nr = nk + 6;
    rc = 8'h01;
    for (int i = 0; i < nk; i++) w[i] = k[32*(nk-1-i) +: 32];
    for (int i = nk; i < 4*(nr+1); i++) begin
      tmp = w[i-1];
      if (i % nk == 0) begin
        tmp = subw({tmp[23:0], tmp[31:24]}) ^ {rc, 24'h0};
        rc  = gm(rc, 8'h02);
      end else if (nk == 8 && i % nk == 4) begin
        tmp = subw(tmp);
      end
      w[i] = w[i-nk] ^ tmp;
    end
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++) s[r][c] = pt[127-8*(4*c+r) -: 8];
    for (int rd = 0; rd <= nr; rd++) begin
      if (rd > 0) begin
        for (int r = 0; r < 4; r++)
          for (int c = 0; c < 4; c++) t[r][c] = sb_t[s[r][(c+r)%4]];
        for (int c = 0; c < 4; c++) begin
          if (rd < nr) begin
            s[0][c] = gm(t[0][c], 8'h02) ^ gm(t[1][c], 8'h03) ^ t[2][c] ^ t[3][c];
            s[1][c] = t[0][c] ^ gm(t[1][c], 8'h02) ^ gm(t[2][c], 8'h03) ^ t[3][c];
            s[2][c] = t[0][c] ^ t[1][c] ^ gm(t[2][c], 8'h02) ^ gm(t[3][c], 8'h03);
            s[3][c] = gm(t[0][c], 8'h03) ^ t[1][c] ^ t[2][c] ^ gm(t[3][c], 8'h02);
          end else begin
            for (int r = 0; r < 4; r++) s[r][c] = t[r][c];
          end
        end
      end
      for (int r = 0; r < 4; r++)
        for (int c = 0; c < 4; c++) s[r][c] = s[r][c] ^ w[4*rd+c][31-8*r -: 8];
    end
    o = '0;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++) o[127-8*(4*c+r) -: 8] = s[r][c];
    return o;
  endfunction

  task automatic check(input string name, input logic [127:0] got, input logic [127:0] want);
    n_vec++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got %h, want %h", name, got, want);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      if ((done_enc && done_dec) || (done_enc && prev_enc) || (done_dec && prev_dec)) begin
        n_err++;
        $display("FAIL done_shape: enc=%0b dec=%0b prev_enc=%0b prev_dec=%0b at edge %0d, want single exclusive pulses",
                 done_enc, done_dec, prev_enc, prev_dec, cyc);
      end
      if (done_enc || done_dec) begin
        n_vec++;
        if (sb.size() == 0) begin
          n_err++;
          $display("FAIL stray_done: enc=%0b dec=%0b at edge %0d, want no pulse", done_enc, done_dec, cyc);
        end else begin
          e = sb.pop_front();
          if (e.dec != done_dec || data_out !== e.data || cyc != e.edge_no) begin
            n_err++;
            $display("FAIL %s: got dec=%0b data_out=%h at edge %0d, want dec=%0b data_out=%h at edge %0d",
                     e.dec ? "dec_result" : "enc_result", done_dec, data_out, cyc, e.dec, e.data, e.edge_no);
          end
        end
      end
    end
    prev_enc = done_enc && !rst;
    prev_dec = done_dec && !rst;
  end

  task automatic run(input logic [1:0] sel, input logic [255:0] k, input logic [127:0] pt,
                     input logic [127:0] exp_ct, input logic [127:0] ct2,
                     input logic [127:0] exp_pt2, input int abort_at);
    int nk, nr, e1;
    nk = nk_of(sel);
    nr = nk + 6;
    e1 = 1 + 4*(nr+1) - nk + nr + 1;
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("rst_data_out", data_out, '0);
    check("rst_done", {126'b0, done_enc, done_dec}, '0);
    sb.delete();
    @(negedge clk);
    nk_val  = sel;
    key     = k;
    data_in = pt;
    sb.push_back('{1'b0, exp_ct, e1});
    sb.push_back('{1'b1, exp_pt2, e1 + nr + 2});
    rst = 1'b0;
    for (int t = 0; t < 300 && sb.size() != 0; t++) begin
      @(negedge clk);
      if (abort_at > 0 && cyc == abort_at) begin
        #2 rst = 1'b1;
        #1;
        check("abort_data_out", data_out, '0);
        check("abort_done", {126'b0, done_enc, done_dec}, '0);
        sb.delete();
        return;
      end
      data_in = done_enc ? ct2 : rnd128();
      key     = rnd256();
      nk_val  = 2'($urandom());
    end
    n_vec++;
    if (sb.size() != 0) begin
      n_err++;
      $display("FAIL timeout: %0d results outstanding, want 0", sb.size());
      sb.delete();
    end
    check("halt_data_out", data_out, exp_pt2);
    repeat (100) begin
      @(negedge clk);
      data_in = rnd128();
      key     = rnd256();
    end
    check("halt_hold", data_out, exp_pt2);
    check("halt_done", {126'b0, done_enc, done_dec}, '0);
  endtask

  initial begin
    logic [255:0] k;
    logic [127:0] p, p2;
    logic [1:0]   s;
    logic [7:0]   inv, v;
    logic [7:0]   cst;
    cst = 8'h63;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++) if (gm(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      for (int i = 0; i < 8; i++)
        v[i] = inv[i] ^ inv[(i+4)%8] ^ inv[(i+5)%8] ^ inv[(i+6)%8] ^ inv[(i+7)%8] ^ cst[i];
      sb_t[x] = v;
    end

    p = 128'h00112233445566778899aabbccddeeff;
    k = {rnd128(), 128'h000102030405060708090a0b0c0d0e0f};
    run(2'b00, k, p, 128'h69c4e0d86a7b0430d8cdb78070b4c55a, 128'h69c4e0d86a7b0430d8cdb78070b4c55a, p, 0);
    k = {$urandom(), $urandom(), 192'h000102030405060708090a0b0c0d0e0f1011121314151617};
    run(2'b01, k, p, 128'hdda97ca4864cdfe06eaf70a0ec0d7191, 128'hdda97ca4864cdfe06eaf70a0ec0d7191, p, 0);
    k = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
    run(2'b10, k, p, 128'h8ea2b7ca516745bfeafc49904b496089, 128'h8ea2b7ca516745bfeafc49904b496089, p, 71);
    run(2'b10, k, p, 128'h8ea2b7ca516745bfeafc49904b496089, 128'h8ea2b7ca516745bfeafc49904b496089, p, 0);
    k = {rnd128(), 128'h000102030405060708090a0b0c0d0e0f};
    run(2'b00, k, p, 128'h69c4e0d86a7b0430d8cdb78070b4c55a, 128'h69c4e0d86a7b0430d8cdb78070b4c55a, p, 20);
    run(2'b00, k, p, 128'h69c4e0d86a7b0430d8cdb78070b4c55a, 128'h69c4e0d86a7b0430d8cdb78070b4c55a, p, 0);

    repeat (8) begin
      s  = 2'($urandom());
      k  = rnd256();
      p  = rnd128();
      p2 = rnd128();
      run(s, k, p, ref_enc(k, nk_of(s), p), ref_enc(k, nk_of(s), p2), p2, 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
